cell_plotter: RTL

Drawing back end for the Life simulator. Consumes the stream of changed-cell coordinates produced by the simulation core and turns each one into a single-pixel write on the 160x120, 3-bit-colour VGA adapter port (x, y, colour, writeEn). Also performs a full-screen clear sweep on request. It sits between the simulation core and the VGA adapter in the top level. A small FIFO decouples the core's burst output from the one-pixel-per-cycle plot port.

---
 rtl/cell_plot_pkg.sv | 29 ++
 rtl/cell_plotter_if.sv | 28 ++
 rtl/cell_plotter_fifo.sv | 67 ++++++
 rtl/cell_plotter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cell_plot_pkg.sv
// Shared types and constants for the Life drawing back end.
// Screen geometry, colours, FSM states and the queued cell record.
package cell_plot_pkg;

    localparam logic [7:0] SCREEN_W = 8'd160;
    localparam logic [6:0] SCREEN_H = 7'd120;
    localparam logic [7:0] X_LAST   = 8'd159;
    localparam logic [6:0] Y_LAST   = 7'd119;

    localparam logic [2:0] COLOUR_ALIVE = 3'b111;
    localparam logic [2:0] COLOUR_DEAD  = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLOT  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       alive;
    } cell_t;

    function automatic logic cell_in_range(cell_t c);
        return (c.x < SCREEN_W) && (c.y < SCREEN_H);
    endfunction

endpackage

// File: rtl/cell_plotter_if.sv
// Cell-update stream from the simulation core and the
// pixel write port towards the VGA adapter.
interface cell_plotter_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic       in_alive;

    modport master (
        output in_valid, in_x, in_y, in_alive,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_x, in_y, in_alive,
        output in_ready
    );
endinterface

interface cell_plotter_vga_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;

    modport master (output x, y, colour, writeEn);
    modport slave  (input  x, y, colour, writeEn);
endinterface

// File: rtl/cell_plotter_fifo.sv
// Small first-word-fall-through buffer of cell updates.
// Flush empties it in one edge and wins over push/pop.
module plot_fifo
    import cell_plot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  push_i,
    input  logic  pop_i,
    input  logic  flush_i,
    input  cell_t data_i,
    output cell_t data_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    cell_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // Storage array; contents are only meaningful below count_q.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cell_plotter.sv
// Turns queued cell updates into single-pixel VGA writes
// and runs a full-screen clear sweep on request.
module cell_plotter
    import cell_plot_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [2:0] ALIVE_COLOUR = COLOUR_ALIVE,
    parameter logic [2:0] DEAD_COLOUR  = COLOUR_DEAD
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear_req,
    cell_plotter_if.slave      in_if,
    cell_plotter_vga_if.master vga_if,
    output logic               busy
);

    state_t     state_q, state_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       we_q, we_d;

    logic  fifo_full;
    logic  fifo_empty;
    logic  push;
    logic  pop;
    cell_t in_cell;
    cell_t head;

    assign in_if.in_ready = !fifo_full && (state_q != CLEAR) && !clear_req;
    assign push           = in_if.in_valid && in_if.in_ready;
    assign in_cell        = '{x: in_if.in_x, y: in_if.in_y,
                              alive: in_if.in_alive};

    plot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (clear_req),
        .data_i  (in_cell),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next state, FIFO pop and next pixel to present.
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        we_d     = 1'b0;
        pop      = 1'b0;
        if (clear_req) begin
            state_d  = CLEAR;
            cx_d     = '0;
            cy_d     = '0;
            x_d      = '0;
            y_d      = '0;
            colour_d = DEAD_COLOUR;
            we_d     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_d = PLOT;
                    end
                end
                PLOT: begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end else begin
                        pop = 1'b1;
                        if (cell_in_range(head)) begin
                            x_d      = head.x;
                            y_d      = head.y;
                            colour_d = head.alive ? ALIVE_COLOUR
                                                  : DEAD_COLOUR;
                            we_d     = 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (cx_q == X_LAST && cy_q == Y_LAST) begin
                        state_d = IDLE;
                    end else begin
                        if (cx_q == X_LAST) begin
                            cx_d = '0;
                            cy_d = cy_q + 7'd1;
                        end else begin
                            cx_d = cx_q + 8'd1;
                        end
                        x_d      = cx_d;
                        y_d      = cy_d;
                        colour_d = DEAD_COLOUR;
                        we_d     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, sweep counters and registered pixel outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            we_q     <= we_d;
        end
    end

    assign vga_if.x       = x_q;
    assign vga_if.y       = y_q;
    assign vga_if.colour  = colour_q;
    assign vga_if.writeEn = we_q;
    assign busy           = !fifo_empty || (state_q != IDLE);

endmodule
